// File: rtl/pong_pkg.sv
// Shared types and constants for the Pong match sequencing logic.
package pong_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SERVE_WAIT,
    PLAY,
    POINT,
    GAME_OVER
  } state_t;

  localparam logic SIDE_LEFT  = 1'b0;
  localparam logic SIDE_RIGHT = 1'b1;

  localparam int MAX_SCORE = 99;
  localparam int SCORE_W   = 7;

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    if (v >= SCORE_W'(MAX_SCORE)) return v;
    return v + SCORE_W'(1);
  endfunction

endpackage

// File: rtl/serve_timer.sv
// Serve-delay down-counter: preset while load is high, counts while en is high,
// done fires on the enabled cycle in which the count has reached zero.
module serve_timer #(
  parameter int DELAY = 50_000_000,
  parameter int W     = 26
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= W'(DELAY - 1);
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign done = en && !load && (cnt == '0);

endmodule

// File: rtl/match_controller.sv
// Pong match sequencer: turns misses into score pulses, times the serve and
// detects game over. Drives the two score_counter instances.
//
// state      | meaning
// IDLE       | after reset, waiting for a start edge
// SERVE_WAIT | ball held at centre while the serve timer runs
// PLAY       | ball in motion, watching for misses
// POINT      | one cycle: inc pulse out, mirror updated, win check
// GAME_OVER  | play frozen, winner latched, waiting for a start edge
module match_controller
  import pong_pkg::*;
#(
  parameter int WIN_SCORE   = 11,
  parameter int SERVE_DELAY = 50_000_000,
  parameter int DLY_W       = 26
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic pause,
  input  logic miss_left,
  input  logic miss_right,
  output logic inc_left,
  output logic inc_right,
  output logic clear_scores,
  output logic ball_reset,
  output logic play_en,
  output logic serve_dir,
  output logic game_over,
  output logic winner
);

  localparam logic [SCORE_W-1:0] WIN_VAL = SCORE_W'(WIN_SCORE);

  state_t               state;
  logic                 start_q;
  logic                 start_edge;
  logic [SCORE_W-1:0]   score_l;
  logic [SCORE_W-1:0]   score_r;
  logic [SCORE_W-1:0]   next_l;
  logic [SCORE_W-1:0]   next_r;
  logic                 timer_load;
  logic                 timer_en;
  logic                 timer_done;

  assign start_edge = start && !start_q;
  assign next_l     = sat_inc(score_l);
  assign next_r     = sat_inc(score_r);

  // The timer stays preset outside SERVE_WAIT so every wait starts full.
  assign timer_load = (state != SERVE_WAIT);
  assign timer_en   = (state == SERVE_WAIT) && !pause;

  serve_timer #(
    .DELAY (SERVE_DELAY),
    .W     (DLY_W)
  ) u_serve_timer (
    .clk   (clk),
    .reset (reset),
    .load  (timer_load),
    .en    (timer_en),
    .done  (timer_done)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      start_q      <= 1'b0;
      score_l      <= '0;
      score_r      <= '0;
      inc_left     <= 1'b0;
      inc_right    <= 1'b0;
      clear_scores <= 1'b0;
      ball_reset   <= 1'b1;
      play_en      <= 1'b0;
      serve_dir    <= SIDE_LEFT;
      game_over    <= 1'b0;
      winner       <= SIDE_LEFT;
    end else begin
      start_q      <= start;
      inc_left     <= 1'b0;
      inc_right    <= 1'b0;
      clear_scores <= 1'b0;

      case (state)
        IDLE, GAME_OVER: begin
          if (start_edge) begin
            clear_scores <= 1'b1;
            score_l      <= '0;
            score_r      <= '0;
            game_over    <= 1'b0;
            state        <= SERVE_WAIT;
          end
        end

        SERVE_WAIT: begin
          if (timer_done) begin
            ball_reset <= 1'b0;
            play_en    <= 1'b1;
            state      <= PLAY;
          end
        end

        PLAY: begin
          play_en <= !pause;
          if (miss_left && miss_right) begin
            ball_reset <= 1'b1;
            play_en    <= 1'b0;
            state      <= SERVE_WAIT;
          end else if (miss_right) begin
            inc_left   <= 1'b1;
            serve_dir  <= SIDE_RIGHT;
            ball_reset <= 1'b1;
            play_en    <= 1'b0;
            state      <= POINT;
          end else if (miss_left) begin
            inc_right  <= 1'b1;
            serve_dir  <= SIDE_LEFT;
            ball_reset <= 1'b1;
            play_en    <= 1'b0;
            state      <= POINT;
          end
        end

        POINT: begin
          // inc_left/inc_right are high exactly in this cycle and name the scorer.
          if (inc_left) begin
            score_l <= next_l;
            if (next_l == WIN_VAL) begin
              game_over <= 1'b1;
              winner    <= SIDE_LEFT;
              state     <= GAME_OVER;
            end else begin
              state <= SERVE_WAIT;
            end
          end else begin
            score_r <= next_r;
            if (next_r == WIN_VAL) begin
              game_over <= 1'b1;
              winner    <= SIDE_RIGHT;
              state     <= GAME_OVER;
            end else begin
              state <= SERVE_WAIT;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
